// File: rtl/symbol_draw_scheduler_if.sv
// Requester and drawing-engine signal bundle for symbol_draw_scheduler.
// slave = scheduler side, master = requesters plus engine side.
interface symbol_draw_scheduler_if #(
    parameter int N  = 4,
    parameter int XW = 8,
    parameter int YW = 7
);
    logic [N-1:0]    req;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic [N-1:0]    req_erase;
    logic            draw_done;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            err;
    logic [XW-1:0]   sym_x;
    logic [YW-1:0]   sym_y;
    logic            sym_en;
    logic            sym_clear_n;
    logic            erase;
    logic            plot;
    logic            busy;

    modport master (
        output req, req_x, req_y, req_erase, draw_done,
        input  grant, done, err, sym_x, sym_y,
        input  sym_en, sym_clear_n, erase, plot, busy
    );

    modport slave (
        input  req, req_x, req_y, req_erase, draw_done,
        output grant, done, err, sym_x, sym_y,
        output sym_en, sym_clear_n, erase, plot, busy
    );
endinterface

// File: rtl/symbol_draw_scheduler.sv
// Round-robin owner of the shared symbol engine and VGA plot strobe,
// with a per-job watchdog that forces completion on a stuck engine.
module symbol_draw_scheduler #(
    parameter int N       = 4,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic reset,
    symbol_draw_scheduler_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] g_q, g_d;
    logic [7:0]    wd_q, wd_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  done_q, done_d;
    logic          err_q, err_d;
    logic [XW-1:0] sym_x_q, sym_x_d;
    logic [YW-1:0] sym_y_q, sym_y_d;
    logic          sym_en_q, sym_en_d;
    logic          sym_clear_n_q, sym_clear_n_d;
    logic          erase_q, erase_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;

    logic          pick_vld;
    logic [IW-1:0] pick;
    logic [IW:0]   idx;

    // First set request at or after ptr, wrapping modulo N.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!pick_vld && bus.req[idx[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        g_d           = g_q;
        wd_d          = wd_q;
        grant_d       = grant_q;
        done_d        = '0;
        err_d         = 1'b0;
        sym_x_d       = sym_x_q;
        sym_y_d       = sym_y_q;
        sym_en_d      = sym_en_q;
        sym_clear_n_d = sym_clear_n_q;
        erase_d       = erase_q;
        plot_d        = plot_q;
        busy_d        = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d       = LOAD;
                    g_d           = pick;
                    sym_x_d       = bus.req_x[pick*XW +: XW];
                    sym_y_d       = bus.req_y[pick*YW +: YW];
                    erase_d       = bus.req_erase[pick];
                    grant_d       = ONE << pick;
                    busy_d        = 1'b1;
                    wd_d          = '0;
                    sym_en_d      = 1'b0;
                    sym_clear_n_d = 1'b0;
                    plot_d        = 1'b0;
                end
            end
            LOAD: begin
                state_d       = DRAW;
                sym_en_d      = 1'b1;
                sym_clear_n_d = 1'b1;
                plot_d        = 1'b0;
            end
            DRAW: begin
                wd_d = wd_q + 8'd1;
                if (bus.draw_done || wd_q == 8'(TIMEOUT - 1)) begin
                    state_d       = ACK;
                    sym_en_d      = 1'b0;
                    sym_clear_n_d = 1'b0;
                    plot_d        = 1'b0;
                    done_d        = grant_q;
                    err_d         = !bus.draw_done;
                end else begin
                    // engine output register lags one cycle behind enable
                    plot_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                if (g_q == IW'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = g_q + IW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            g_q           <= '0;
            wd_q          <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            err_q         <= 1'b0;
            sym_x_q       <= '0;
            sym_y_q       <= '0;
            sym_en_q      <= 1'b0;
            sym_clear_n_q <= 1'b0;
            erase_q       <= 1'b0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            g_q           <= g_d;
            wd_q          <= wd_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            err_q         <= err_d;
            sym_x_q       <= sym_x_d;
            sym_y_q       <= sym_y_d;
            sym_en_q      <= sym_en_d;
            sym_clear_n_q <= sym_clear_n_d;
            erase_q       <= erase_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.sym_x       = sym_x_q;
    assign bus.sym_y       = sym_y_q;
    assign bus.sym_en      = sym_en_q;
    assign bus.sym_clear_n = sym_clear_n_q;
    assign bus.erase       = erase_q;
    assign bus.plot        = plot_q;
    assign bus.busy        = busy_q;
endmodule
